// File: rtl/knapsack_search_if.sv
// Control/result bundle for knapsack_search: item table load, limits, start,
// and the search status/result outputs.
interface knapsack_search_if #(
  parameter int N_ITEMS = 5,
  parameter int ITEM_W  = 8,
  parameter int SUM_W   = 12,
  parameter int IDX_W   = 3
);
  logic                 load_en;
  logic [IDX_W-1:0]     load_idx;
  logic [ITEM_W-1:0]    load_weight;
  logic [ITEM_W-1:0]    load_value;
  logic [ITEM_W-1:0]    load_volume;
  logic [SUM_W-1:0]     max_weight;
  logic [SUM_W-1:0]     max_volume;
  logic [SUM_W-1:0]     min_value;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 found;
  logic [N_ITEMS-1:0]   best_mask;
  logic [SUM_W-1:0]     best_value;
  logic [SUM_W-1:0]     best_weight;
  logic [SUM_W-1:0]     best_volume;

  modport master (
    output load_en, load_idx, load_weight, load_value, load_volume,
           max_weight, max_volume, min_value, start,
    input  busy, done, found, best_mask, best_value, best_weight, best_volume
  );

  modport slave (
    input  load_en, load_idx, load_weight, load_value, load_volume,
           max_weight, max_volume, min_value, start,
    output busy, done, found, best_mask, best_value, best_weight, best_volume
  );
endinterface

// File: rtl/knapsack_search.sv
// Exhaustive 0-1 knapsack search: one selection mask per clock over all
// 2^N_ITEMS masks, keeping the best-value mask that meets weight/volume/value.
module knapsack_search #(
  parameter int N_ITEMS = 5,
  parameter int ITEM_W  = 8,
  parameter int SUM_W   = 12,
  parameter int IDX_W   = 3
) (
  input logic              clk,
  input logic              rst_n,
  knapsack_search_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t             state_q, state_d;
  logic [N_ITEMS-1:0] mask_q, mask_d;
  logic [N_ITEMS-1:0] best_mask_q, best_mask_d;
  logic [SUM_W-1:0]   lim_w_q, lim_w_d, lim_vol_q, lim_vol_d, lim_v_q, lim_v_d;
  logic [SUM_W-1:0]   best_v_q, best_v_d, best_w_q, best_w_d, best_vol_q, best_vol_d;
  logic               found_q, found_d, busy_q, busy_d, done_q, done_d;
  logic [ITEM_W-1:0]  tw_q [N_ITEMS];
  logic [ITEM_W-1:0]  tw_d [N_ITEMS];
  logic [ITEM_W-1:0]  tv_q [N_ITEMS];
  logic [ITEM_W-1:0]  tv_d [N_ITEMS];
  logic [ITEM_W-1:0]  tvol_q [N_ITEMS];
  logic [ITEM_W-1:0]  tvol_d [N_ITEMS];
  logic [SUM_W-1:0]   sum_w, sum_v, sum_vol;
  logic               qualify;

  always_comb begin
    sum_w   = '0;
    sum_v   = '0;
    sum_vol = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (mask_q[i]) begin
        sum_w   = sum_w   + SUM_W'(tw_q[i]);
        sum_v   = sum_v   + SUM_W'(tv_q[i]);
        sum_vol = sum_vol + SUM_W'(tvol_q[i]);
      end
    end
    qualify = (sum_w <= lim_w_q) && (sum_vol <= lim_vol_q) && (sum_v >= lim_v_q);
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    best_mask_d = best_mask_q;
    lim_w_d     = lim_w_q;
    lim_vol_d   = lim_vol_q;
    lim_v_d     = lim_v_q;
    best_v_d    = best_v_q;
    best_w_d    = best_w_q;
    best_vol_d  = best_vol_q;
    found_d     = found_q;
    tw_d        = tw_q;
    tv_d        = tv_q;
    tvol_d      = tvol_q;

    // Out-of-range indices never match any entry, so they are dropped here.
    if (bus.load_en && state_q != SEARCH) begin
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
        if (bus.load_idx == IDX_W'(i)) begin
          tw_d[i]   = bus.load_weight;
          tv_d[i]   = bus.load_value;
          tvol_d[i] = bus.load_volume;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          lim_w_d     = bus.max_weight;
          lim_vol_d   = bus.max_volume;
          lim_v_d     = bus.min_value;
          found_d     = 1'b0;
          best_mask_d = '0;
          best_v_d    = '0;
          best_w_d    = '0;
          best_vol_d  = '0;
          mask_d      = '0;
          state_d     = SEARCH;
        end
      end
      SEARCH: begin
        if (qualify && (!found_q || sum_v > best_v_q)) begin
          found_d     = 1'b1;
          best_mask_d = mask_q;
          best_v_d    = sum_v;
          best_w_d    = sum_w;
          best_vol_d  = sum_vol;
        end
        mask_d = mask_q + N_ITEMS'(1);
        if (mask_q == '1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SEARCH);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      best_mask_q <= '0;
      lim_w_q     <= '0;
      lim_vol_q   <= '0;
      lim_v_q     <= '0;
      best_v_q    <= '0;
      best_w_q    <= '0;
      best_vol_q  <= '0;
      found_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
        tw_q[i]   <= '0;
        tv_q[i]   <= '0;
        tvol_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      best_mask_q <= best_mask_d;
      lim_w_q     <= lim_w_d;
      lim_vol_q   <= lim_vol_d;
      lim_v_q     <= lim_v_d;
      best_v_q    <= best_v_d;
      best_w_q    <= best_w_d;
      best_vol_q  <= best_vol_d;
      found_q     <= found_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tw_q        <= tw_d;
      tv_q        <= tv_d;
      tvol_q      <= tvol_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.found       = found_q;
  assign bus.best_mask   = best_mask_q;
  assign bus.best_value  = best_v_q;
  assign bus.best_weight = best_w_q;
  assign bus.best_volume = best_vol_q;
endmodule

// File: tb/tb_knapsack_search.sv
// Scoreboard bench for knapsack_search: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_knapsack_search;
  localparam int N_ITEMS = 5;
  localparam int ITEM_W  = 8;
  localparam int SUM_W   = 12;
  localparam int IDX_W   = 3;

  typedef struct packed {
    logic             found;
    logic [4:0]       mask;
    logic [11:0]      value;
    logic [11:0]      weight;
    logic [11:0]      volume;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  knapsack_search_if #(.N_ITEMS(N_ITEMS), .ITEM_W(ITEM_W), .SUM_W(SUM_W), .IDX_W(IDX_W)) bus ();

  knapsack_search #(.N_ITEMS(N_ITEMS), .ITEM_W(ITEM_W), .SUM_W(SUM_W), .IDX_W(IDX_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("found",       32'(bus.found),       32'(e.found));
        chk("best_mask",   32'(bus.best_mask),   32'(e.mask));
        chk("best_value",  32'(bus.best_value),  32'(e.value));
        chk("best_weight", 32'(bus.best_weight), 32'(e.weight));
        chk("best_volume", 32'(bus.best_volume), 32'(e.volume));
      end
    end
  end

  task automatic load(input int idx, input int w, input int v, input int vol);
    bus.load_en     = 1'b1;
    bus.load_idx    = IDX_W'(idx);
    bus.load_weight = ITEM_W'(w);
    bus.load_value  = ITEM_W'(v);
    bus.load_volume = ITEM_W'(vol);
    @(posedge clk); #1;
    bus.load_en = 1'b0;
  endtask

  task automatic limits(input int w, input int vol, input int minv);
    bus.max_weight = SUM_W'(w);
    bus.max_volume = SUM_W'(vol);
    bus.min_value  = SUM_W'(minv);
  endtask

  task automatic load_table_a();
    load(0, 12, 4, 1);
    load(1, 1, 2, 1);
    load(2, 2, 2, 1);
    load(3, 1, 1, 1);
    load(4, 4, 10, 1);
  endtask

  // Starts a run and times it; perturb injects start/load/limit changes mid-search.
  task automatic run_search(input exp_t e, input bit perturb);
    int edges;
    int busy_cnt;
    logic [SUM_W-1:0] saved_w;
    saved_w = bus.max_weight;
    sb_q.push_back(e);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edges = 1;
    busy_cnt = bus.busy ? 1 : 0;
    while (!bus.done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (bus.busy) busy_cnt++;
      if (perturb && edges == 5) begin
        bus.start = 1'b1;
        bus.load_en = 1'b1;
        bus.load_idx = '0;
        bus.load_weight = 8'd0;
        bus.load_value = 8'd99;
        bus.load_volume = 8'd0;
        bus.max_weight = '0;
      end else if (perturb && edges == 6) begin
        bus.start = 1'b0;
        bus.load_en = 1'b0;
      end
    end
    bus.max_weight = saved_w;
    chk("done_latency", 32'(edges), 32'd33);
    chk("busy_cycles", 32'(busy_cnt), 32'd32);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.load_en = 1'b0;
    bus.load_idx = '0;
    bus.load_weight = '0;
    bus.load_value = '0;
    bus.load_volume = '0;
    bus.start = 1'b0;
    limits(15, 6, 15);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_found", 32'(bus.found), 32'd0);
    chk("rst_best_mask", 32'(bus.best_mask), 32'd0);
    chk("rst_best_value", 32'(bus.best_value), 32'd0);

    // Zeroed table with min 0: every mask has value 0, mask 0 wins.
    limits(15, 6, 0);
    load(7, 50, 50, 50);
    load(5, 50, 50, 50);
    run_search('{1'b1, 5'h00, 12'd0, 12'd0, 12'd0}, 1'b0);

    load_table_a();
    limits(15, 6, 15);
    run_search('{1'b1, 5'h1E, 12'd15, 12'd8, 12'd4}, 1'b0);

    limits(15, 6, 16);
    run_search('{1'b0, 5'h00, 12'd0, 12'd0, 12'd0}, 1'b0);
    chk("hold_found", 32'(bus.found), 32'd0);

    limits(15, 3, 0);
    run_search('{1'b1, 5'h16, 12'd14, 12'd7, 12'd3}, 1'b0);
    chk("hold_best_mask", 32'(bus.best_mask), 32'h16);

    limits(15, 6, 15);
    run_search('{1'b1, 5'h1E, 12'd15, 12'd8, 12'd4}, 1'b1);
    run_search('{1'b1, 5'h1E, 12'd15, 12'd8, 12'd4}, 1'b0);

    load(0, 1, 5, 1);
    load(1, 1, 5, 1);
    load(2, 0, 0, 0);
    load(3, 0, 0, 0);
    load(4, 0, 0, 0);
    limits(1, 6, 0);
    run_search('{1'b1, 5'h01, 12'd5, 12'd1, 12'd1}, 1'b0);

    // Abort mid-search with reset: no done may follow, table must be cleared.
    load_table_a();
    limits(15, 6, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_found", 32'(bus.found), 32'd0);
    chk("abort_best_mask", 32'(bus.best_mask), 32'd0);
    chk("abort_best_value", 32'(bus.best_value), 32'd0);
    chk("abort_best_weight", 32'(bus.best_weight), 32'd0);
    chk("abort_best_volume", 32'(bus.best_volume), 32'd0);
    repeat (40) @(posedge clk);
    #1 chk("abort_idle", 32'(bus.busy), 32'd0);
    run_search('{1'b1, 5'h00, 12'd0, 12'd0, 12'd0}, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
